// File: rtl/tlb_controller.sv
// TLB sequencing controller: lookup, LRU maintenance, page-table-walk refill and flush
// for a set-associative storage array with a combinational read port.
module tlb_controller #(
  parameter int NUM_SETS       = 16,
  parameter int NUM_WAYS       = 4,
  parameter int SET_INDEX_BITS = 4,
  parameter int WAY_BITS       = 2,
  parameter int LRU_BITS       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [31:0]                  req_vaddr,
  input  logic                         req_write,
  output logic                         resp_valid,
  output logic [31:0]                  resp_paddr,
  output logic                         resp_fault,
  input  logic                         flush_req,
  output logic                         flush_done,
  output logic                         ptw_req,
  output logic [19:0]                  ptw_vpn,
  input  logic                         ptw_ack,
  input  logic [19:0]                  ptw_ppn,
  input  logic [1:0]                   ptw_perms,
  input  logic                         ptw_fault,
  output logic [SET_INDEX_BITS-1:0]    st_rd_set_index,
  input  logic [NUM_WAYS-1:0]          st_rd_valid,
  input  logic [20*NUM_WAYS-1:0]       st_rd_vpn,
  input  logic [20*NUM_WAYS-1:0]       st_rd_ppn,
  input  logic [2*NUM_WAYS-1:0]        st_rd_perms,
  input  logic [LRU_BITS*NUM_WAYS-1:0] st_rd_lru,
  output logic                         st_wr_en,
  output logic [SET_INDEX_BITS-1:0]    st_wr_set_index,
  output logic [WAY_BITS-1:0]          st_wr_way,
  output logic                         st_wr_valid,
  output logic [19:0]                  st_wr_vpn,
  output logic [19:0]                  st_wr_ppn,
  output logic [1:0]                   st_wr_perms,
  output logic [LRU_BITS-1:0]          st_wr_lru,
  output logic                         st_lru_en,
  output logic [SET_INDEX_BITS-1:0]    st_lru_set_index,
  output logic [WAY_BITS-1:0]          st_lru_way,
  output logic [LRU_BITS-1:0]          st_lru_value
);

  localparam int                    FLUSH_W    = SET_INDEX_BITS + WAY_BITS;
  localparam logic [LRU_BITS-1:0]   LRU_MAX    = LRU_BITS'(NUM_WAYS - 1);
  localparam logic [WAY_BITS-1:0]   WAY_LAST   = WAY_BITS'(NUM_WAYS - 1);
  localparam logic [FLUSH_W-1:0]    FLUSH_LAST = FLUSH_W'(NUM_SETS * NUM_WAYS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WALK, S_REFILL, S_LRU_UPD, S_FLUSH
  } state_t;

  state_t                         r_state;
  logic [31:0]                    r_vaddr;
  logic                           r_write;
  logic [NUM_WAYS-1:0]            r_snap_valid;
  logic [LRU_BITS*NUM_WAYS-1:0]   r_snap_lru;
  logic [LRU_BITS*NUM_WAYS-1:0]   r_lru_plan;
  logic [WAY_BITS-1:0]            r_cnt;
  logic [FLUSH_W-1:0]             r_fcnt;

  logic                           r_req_ready;
  logic                           r_resp_valid;
  logic [31:0]                    r_resp_paddr;
  logic                           r_resp_fault;
  logic                           r_flush_done;
  logic                           r_ptw_req;
  logic [19:0]                    r_ptw_vpn;
  logic [SET_INDEX_BITS-1:0]      r_rd_set;
  logic                           r_wr_en;
  logic [SET_INDEX_BITS-1:0]      r_wr_set;
  logic [WAY_BITS-1:0]            r_wr_way;
  logic                           r_wr_valid;
  logic [19:0]                    r_wr_vpn;
  logic [19:0]                    r_wr_ppn;
  logic [1:0]                     r_wr_perms;
  logic [LRU_BITS-1:0]            r_wr_lru;
  logic                           r_lru_en;
  logic [SET_INDEX_BITS-1:0]      r_lru_set;
  logic [WAY_BITS-1:0]            r_lru_way;
  logic [LRU_BITS-1:0]            r_lru_value;

  logic [NUM_WAYS-1:0]            w_hit_vec;
  logic                           w_hit;
  logic [WAY_BITS-1:0]            w_hit_way;
  logic [19:0]                    w_hit_ppn;
  logic [1:0]                     w_hit_perms;
  logic [LRU_BITS-1:0]            w_hit_lru;
  logic                           w_hit_fault;
  logic                           w_refill_fault;
  logic                           w_any_invalid;
  logic [WAY_BITS-1:0]            w_victim;
  logic [LRU_BITS-1:0]            w_max_lru;
  logic [LRU_BITS*NUM_WAYS-1:0]   w_src_lru;
  logic [WAY_BITS-1:0]            w_src_acc;
  logic [LRU_BITS-1:0]            w_src_old;
  logic [LRU_BITS*NUM_WAYS-1:0]   w_plan;
  logic [WAY_BITS-1:0]            w_cnt_next;
  logic [LRU_BITS-1:0]            w_plan_next;
  logic [FLUSH_W-1:0]             w_fcnt_next;

  generate
    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_match
      assign w_hit_vec[gi] = st_rd_valid[gi] && (st_rd_vpn[20*gi +: 20] == r_vaddr[31:12]);
    end
  endgenerate

  // Descending scan so the lowest matching way is the one left standing.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_hit_ppn   = '0;
    w_hit_perms = '0;
    w_hit_lru   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (w_hit_vec[w]) begin
        w_hit       = 1'b1;
        w_hit_way   = WAY_BITS'(w);
        w_hit_ppn   = st_rd_ppn[20*w +: 20];
        w_hit_perms = st_rd_perms[2*w +: 2];
        w_hit_lru   = st_rd_lru[LRU_BITS*w +: LRU_BITS];
      end
    end
  end

  assign w_hit_fault    = r_write ? ~w_hit_perms[1] : ~w_hit_perms[0];
  assign w_refill_fault = r_write ? ~r_wr_perms[1] : ~r_wr_perms[0];

  // Victim: lowest invalid way, else the oldest (first maximum) way.
  always_comb begin
    w_any_invalid = 1'b0;
    w_victim      = '0;
    w_max_lru     = r_snap_lru[LRU_BITS-1:0];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!r_snap_valid[w]) begin
        w_any_invalid = 1'b1;
        w_victim      = WAY_BITS'(w);
      end
    end
    if (!w_any_invalid) begin
      for (int w = 1; w < NUM_WAYS; w++) begin
        if (r_snap_lru[LRU_BITS*w +: LRU_BITS] > w_max_lru) begin
          w_max_lru = r_snap_lru[LRU_BITS*w +: LRU_BITS];
          w_victim  = WAY_BITS'(w);
        end
      end
    end
  end

  // The whole LRU update is planned at entry; LOOKUP uses live read data, REFILL the snapshot.
  assign w_src_lru = (r_state == S_LOOKUP) ? st_rd_lru : r_snap_lru;
  assign w_src_acc = (r_state == S_LOOKUP) ? w_hit_way : w_victim;
  assign w_src_old = (r_state == S_LOOKUP) ? w_hit_lru : LRU_MAX;

  generate
    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_plan
      logic [LRU_BITS-1:0] w_cur;
      assign w_cur = w_src_lru[LRU_BITS*gi +: LRU_BITS];
      assign w_plan[LRU_BITS*gi +: LRU_BITS] =
        (WAY_BITS'(gi) == w_src_acc) ? '0 :
        (w_cur < w_src_old) ? ((w_cur == LRU_MAX) ? LRU_MAX : w_cur + LRU_BITS'(1)) :
        w_cur;
    end
  endgenerate

  assign w_cnt_next  = r_cnt + WAY_BITS'(1);
  assign w_fcnt_next = r_fcnt + FLUSH_W'(1);

  always_comb begin
    w_plan_next = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (WAY_BITS'(w) == w_cnt_next) w_plan_next = r_lru_plan[LRU_BITS*w +: LRU_BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_vaddr      <= '0;
      r_write      <= 1'b0;
      r_snap_valid <= '0;
      r_snap_lru   <= '0;
      r_lru_plan   <= '0;
      r_cnt        <= '0;
      r_fcnt       <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_paddr <= '0;
      r_resp_fault <= 1'b0;
      r_flush_done <= 1'b0;
      r_ptw_req    <= 1'b0;
      r_ptw_vpn    <= '0;
      r_rd_set     <= '0;
      r_wr_en      <= 1'b0;
      r_wr_set     <= '0;
      r_wr_way     <= '0;
      r_wr_valid   <= 1'b0;
      r_wr_vpn     <= '0;
      r_wr_ppn     <= '0;
      r_wr_perms   <= '0;
      r_wr_lru     <= '0;
      r_lru_en     <= 1'b0;
      r_lru_set    <= '0;
      r_lru_way    <= '0;
      r_lru_value  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_flush_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (flush_req) begin
            r_state     <= S_FLUSH;
            r_req_ready <= 1'b0;
            r_fcnt      <= '0;
            r_wr_en     <= 1'b1;
            r_wr_set    <= '0;
            r_wr_way    <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_vpn    <= '0;
            r_wr_ppn    <= '0;
            r_wr_perms  <= '0;
            r_wr_lru    <= '0;
          end else if (req_valid) begin
            r_state     <= S_LOOKUP;
            r_req_ready <= 1'b0;
            r_vaddr     <= req_vaddr;
            r_write     <= req_write;
            r_rd_set    <= req_vaddr[12 +: SET_INDEX_BITS];
          end
        end
        S_LOOKUP: begin
          r_snap_valid <= st_rd_valid;
          r_snap_lru   <= st_rd_lru;
          if (w_hit) begin
            r_state      <= S_LRU_UPD;
            r_resp_valid <= 1'b1;
            r_resp_paddr <= {w_hit_ppn, r_vaddr[11:0]};
            r_resp_fault <= w_hit_fault;
            r_lru_en     <= 1'b1;
            r_lru_set    <= r_rd_set;
            r_lru_way    <= '0;
            r_cnt        <= '0;
            r_lru_plan   <= w_plan;
            r_lru_value  <= w_plan[LRU_BITS-1:0];
          end else begin
            r_state   <= S_WALK;
            r_ptw_req <= 1'b1;
            r_ptw_vpn <= r_vaddr[31:12];
          end
        end
        S_WALK: begin
          if (ptw_ack) begin
            r_ptw_req <= 1'b0;
            if (ptw_fault) begin
              r_state      <= S_IDLE;
              r_req_ready  <= 1'b1;
              r_resp_valid <= 1'b1;
              r_resp_fault <= 1'b1;
              r_resp_paddr <= '0;
            end else begin
              r_state    <= S_REFILL;
              r_wr_en    <= 1'b1;
              r_wr_set   <= r_rd_set;
              r_wr_way   <= w_victim;
              r_wr_valid <= 1'b1;
              r_wr_vpn   <= r_vaddr[31:12];
              r_wr_ppn   <= ptw_ppn;
              r_wr_perms <= ptw_perms;
              r_wr_lru   <= '0;
            end
          end
        end
        S_REFILL: begin
          r_state      <= S_LRU_UPD;
          r_wr_en      <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_paddr <= {r_wr_ppn, r_vaddr[11:0]};
          r_resp_fault <= w_refill_fault;
          r_lru_en     <= 1'b1;
          r_lru_set    <= r_rd_set;
          r_lru_way    <= '0;
          r_cnt        <= '0;
          r_lru_plan   <= w_plan;
          r_lru_value  <= w_plan[LRU_BITS-1:0];
        end
        S_LRU_UPD: begin
          if (r_cnt == WAY_LAST) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_lru_en    <= 1'b0;
          end else begin
            r_cnt       <= w_cnt_next;
            r_lru_way   <= w_cnt_next;
            r_lru_value <= w_plan_next;
          end
        end
        S_FLUSH: begin
          if (r_fcnt == FLUSH_LAST) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_wr_en      <= 1'b0;
            r_flush_done <= 1'b1;
          end else begin
            r_fcnt   <= w_fcnt_next;
            r_wr_set <= w_fcnt_next[WAY_BITS +: SET_INDEX_BITS];
            r_wr_way <= w_fcnt_next[WAY_BITS-1:0];
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready        = r_req_ready;
  assign resp_valid       = r_resp_valid;
  assign resp_paddr       = r_resp_paddr;
  assign resp_fault       = r_resp_fault;
  assign flush_done       = r_flush_done;
  assign ptw_req          = r_ptw_req;
  assign ptw_vpn          = r_ptw_vpn;
  assign st_rd_set_index  = r_rd_set;
  assign st_wr_en         = r_wr_en;
  assign st_wr_set_index  = r_wr_set;
  assign st_wr_way        = r_wr_way;
  assign st_wr_valid      = r_wr_valid;
  assign st_wr_vpn        = r_wr_vpn;
  assign st_wr_ppn        = r_wr_ppn;
  assign st_wr_perms      = r_wr_perms;
  assign st_wr_lru        = r_wr_lru;
  assign st_lru_en        = r_lru_en;
  assign st_lru_set_index = r_lru_set;
  assign st_lru_way       = r_lru_way;
  assign st_lru_value     = r_lru_value;

endmodule

// File: doc/tlb_controller.md
Name: tlb_controller

Overview:
Sequencing controller for the set-associative TLB storage array. It accepts translation requests and performs the lookup through the storage read port. On a hit it maintains the per-way LRU counters through the LRU update port. On a miss it runs a page-table-walk handshake, selects a victim and refills it through the write port. It also performs whole-TLB flushes, and sits between the load/store unit and the storage array and page-table walker.

Parameters:
NUM_SETS, 16, number of sets
NUM_WAYS, 4, associativity
SET_INDEX_BITS, 4, log2(NUM_SETS)
WAY_BITS, 2, way index width
LRU_BITS, 2, LRU counter width; counter range 0..NUM_WAYS-1

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  translation request
req_ready  out  1  controller idle and able to accept
req_vaddr  in  32  virtual address
req_write  in  1  1=store (needs perms[1]), 0=load (needs perms[0])
resp_valid  out  1  one-cycle response pulse
resp_paddr  out  32  {ppn, vaddr[11:0]}
resp_fault  out  1  permission or walk fault
flush_req  in  1  invalidate all entries
flush_done  out  1  one-cycle pulse when flush completes
ptw_req  out  1  walk request, held until ack
ptw_vpn  out  20  VPN being walked
ptw_ack  in  1  walk result valid
ptw_ppn  in  20  walk PPN
ptw_perms  in  2  walk permissions
ptw_fault  in  1  walk failed
st_rd_set_index  out  SET_INDEX_BITS  storage read index
st_rd_valid  in  NUM_WAYS  bit w = way w valid
st_rd_vpn  in  20*NUM_WAYS  way w at [20w+19:20w]
st_rd_ppn  in  20*NUM_WAYS  same packing
st_rd_perms  in  2*NUM_WAYS  same packing
st_rd_lru  in  LRU_BITS*NUM_WAYS  same packing
st_wr_en, st_wr_set_index, st_wr_way, st_wr_valid, st_wr_vpn, st_wr_ppn, st_wr_perms, st_wr_lru  out  1/SET_INDEX_BITS/WAY_BITS/1/20/20/2/LRU_BITS  storage write port
st_lru_en, st_lru_set_index, st_lru_way, st_lru_value  out  1/SET_INDEX_BITS/WAY_BITS/LRU_BITS  storage LRU port

Behaviour:
- vpn = vaddr[31:12]; set = vpn[SET_INDEX_BITS-1:0]; storage read is combinational.
- Reset: state IDLE, req_ready=1. resp_valid, resp_fault, flush_done, ptw_req, st_wr_en and st_lru_en are 0. All data outputs are 0. Reset mid-operation abandons it: ptw_req drops the next cycle and a late ptw_ack is ignored.
- States: IDLE, LOOKUP, WALK, REFILL, LRU_UPD, FLUSH.
- IDLE: req_ready=1. flush_req has priority over req_valid and moves to FLUSH. Otherwise req_valid latches vaddr/write and moves to LOOKUP.
- LOOKUP: drive latched set. Hit = valid and vpn-equal; lowest-index way wins on multiple hits. Snapshot valid and lru for all ways.
  - On hit: fault = perm bit clear; go to LRU_UPD with accessed way = hit way and old = its count.
  - On miss: go to WALK.
- WALK: ptw_req=1 with ptw_vpn held until ptw_ack=1; the ack cycle completes the transfer.
  - ptw_fault=1: resp_valid=1, resp_fault=1, resp_paddr=0 next cycle; return to IDLE with no refill.
  - Else go to REFILL.
- REFILL, one cycle: victim = lowest invalid way from the snapshot. If none, victim = way with maximum lru, lowest index on tie.
  - Write st_wr_en=1, valid=1, vpn, ppn, perms, lru=0.
  - Then LRU_UPD with accessed way = victim and old = NUM_WAYS-1.
  - Fault is checked against ptw_perms; the entry is still installed on a permission fault.
- LRU_UPD: exactly NUM_WAYS cycles, way k in cycle k, with st_lru_en=1. The accessed way is written 0. Another way with snapshot count < old is written count+1, saturating at NUM_WAYS-1. Other ways keep their snapshot count.
  - resp_valid pulses in the first LRU_UPD cycle, with paddr/fault.
  - Returns to IDLE afterwards.
- The write and LRU ports are never active in the same cycle.
- FLUSH: NUM_SETS*NUM_WAYS cycles, one entry per cycle in set-major, way-minor order. Each entry is written with valid=0 and all fields 0. flush_done pulses on the cycle after the last write, when the controller returns to IDLE.
- A hit response occurs 2 cycles after acceptance. req_ready is low from acceptance until the return to IDLE.

Test Plan:
- Cold miss vaddr 0x00012345, load -> ptw_req with ptw_vpn 0x00012. Ack with ppn 0xABCDE, perms 2'b11 -> REFILL writes set 2 way 0; resp_paddr 0xABCDE345, fault 0.
- Repeat the same load -> resp_valid 2 cycles after accept, no ptw_req; LRU writes way 0 = 0.
- Five distinct VPNs mapping to set 2 (0x00012, 0x00022, 0x00032, 0x00042, 0x00052) -> fifth refill evicts way 0 (lru 3); counts then read 0, 3, 2, 1 for ways 0-3.
- Store to an entry with perms 2'b01 -> resp_fault=1, paddr still valid, LRU updated; walk fault -> resp_fault=1, no st_wr_en.
- flush_req while req_valid is also high in IDLE -> 64 write cycles clearing valid, flush_done pulse, then the request is accepted and misses.
- Assert rst during WALK, then ptw_ack -> ptw_req=0 after reset, no refill, req_ready=1.
